dds_sweep_ctrl: RTL and testbench

- Control block between the SPI receiver (CLK_50M domain) and the DDS phase accumulator (clk_100M domain).
- Synchronises SPI command/data completion strobes into clk_100M and decodes register-write and run/halt commands.
- Converts frequencies in Hz to frequency tuning words (FTW = Hz × 43).
- Sequences either a fixed-frequency output or a stepped linear frequency sweep with a programmable dwell.

---
 rtl/dds_sweep_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep controller: resynchronises SPI command/data strobes into clk_100M, converts Hz
// to tuning words and sequences fixed-frequency output or a stepped linear sweep.
module dds_sweep_ctrl #(
  parameter int unsigned FTW_MULT    = 43,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic [7:0]  spi_cmd,
  input  logic        spi_cmd_done,
  input  logic [31:0] spi_data,
  input  logic        spi_data_done,
  output logic [31:0] ftw,
  output logic        ftw_valid,
  output logic        sweeping,
  output logic        err,
  output logic [31:0] cur_freq
);

  localparam logic [31:0] FtwMultW = 32'(FTW_MULT);

  localparam logic [7:0] CmdFix   = 8'h01;
  localparam logic [7:0] CmdStart = 8'h02;
  localparam logic [7:0] CmdStop  = 8'h03;
  localparam logic [7:0] CmdStep  = 8'h04;
  localparam logic [7:0] CmdDwell = 8'h05;
  localparam logic [7:0] CmdSweep = 8'h06;
  localparam logic [7:0] CmdHalt  = 8'h07;
  localparam logic [7:0] CmdLoop  = 8'h08;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StApply,
    StDwell,
    StStep
  } state_e;

  // Done-level synchronisers and rising-edge detectors
  logic [SYNC_STAGES-1:0] cmd_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   cmd_prev_q;
  logic                   data_prev_q;
  logic                   cmd_stb;
  logic                   data_stb;

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      cmd_sync_q  <= '0;
      data_sync_q <= '0;
      cmd_prev_q  <= 1'b0;
      data_prev_q <= 1'b0;
    end else begin
      cmd_sync_q  <= {cmd_sync_q[SYNC_STAGES-2:0], spi_cmd_done};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], spi_data_done};
      cmd_prev_q  <= cmd_sync_q[SYNC_STAGES-1];
      data_prev_q <= data_sync_q[SYNC_STAGES-1];
    end
  end

  assign cmd_stb  = cmd_sync_q[SYNC_STAGES-1] & ~cmd_prev_q;
  assign data_stb = data_sync_q[SYNC_STAGES-1] & ~data_prev_q;

  // Sequencer state
  state_e      state_q;
  logic [7:0]  pending_cmd_q;
  logic [31:0] f_start_q;
  logic [31:0] f_stop_q;
  logic [31:0] f_step_q;
  logic [31:0] dwell_q;
  logic [31:0] dwell_cnt_q;
  logic [31:0] product_q;
  logic        loop_q;

  logic [7:0]  eff_cmd;
  logic        sweep_ok;
  logic [32:0] next_sum;
  logic        step_done;
  logic [31:0] dwell_load;

  always_comb begin
    // A same-cycle command is decoded first, so the data word follows the new command.
    eff_cmd    = cmd_stb ? spi_cmd : pending_cmd_q;
    sweep_ok   = (f_step_q != 32'd0) && (f_start_q <= f_stop_q);
    next_sum   = {1'b0, cur_freq} + {1'b0, f_step_q};
    step_done  = next_sum[32] || (next_sum[31:0] > f_stop_q);
    dwell_load = (dwell_q == 32'd0) ? 32'd1 : dwell_q;
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pending_cmd_q <= 8'h00;
      f_start_q     <= '0;
      f_stop_q      <= '0;
      f_step_q      <= '0;
      dwell_q       <= '0;
      dwell_cnt_q   <= '0;
      product_q     <= '0;
      loop_q        <= 1'b0;
      ftw           <= '0;
      ftw_valid     <= 1'b0;
      sweeping      <= 1'b0;
      err           <= 1'b0;
      cur_freq      <= '0;
    end else begin
      ftw_valid <= 1'b0;

      unique case (state_q)
        StIdle: ;
        StLoad: begin
          product_q <= cur_freq * FtwMultW;
          state_q   <= StApply;
        end
        StApply: begin
          ftw       <= product_q;
          ftw_valid <= 1'b1;
          if (sweeping) begin
            dwell_cnt_q <= dwell_load;
            state_q     <= StDwell;
          end else begin
            state_q <= StIdle;
          end
        end
        StDwell: begin
          if (dwell_cnt_q <= 32'd1) begin
            state_q <= StStep;
          end else begin
            dwell_cnt_q <= dwell_cnt_q - 32'd1;
          end
        end
        StStep: begin
          if (step_done) begin
            if (loop_q) begin
              cur_freq <= f_start_q;
              state_q  <= StLoad;
            end else begin
              sweeping <= 1'b0;
              state_q  <= StIdle;
            end
          end else begin
            cur_freq <= next_sum[31:0];
            state_q  <= StLoad;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (cmd_stb) begin
        pending_cmd_q <= spi_cmd;
        case (spi_cmd)
          CmdSweep, CmdLoop: begin
            if (!sweep_ok) begin
              err <= 1'b1;
            end else begin
              cur_freq <= f_start_q;
              loop_q   <= (spi_cmd == CmdLoop);
              sweeping <= 1'b1;
              state_q  <= StLoad;
            end
          end
          CmdHalt: begin
            sweeping <= 1'b0;
            err      <= 1'b0;
            state_q  <= StIdle;
          end
          default: ;
        endcase
      end

      if (data_stb) begin
        case (eff_cmd)
          // The fixed frequency lives only in cur_freq; nothing else reads it back.
          CmdFix: begin
            cur_freq <= spi_data;
            sweeping <= 1'b0;
            loop_q   <= 1'b0;
            state_q  <= StLoad;
          end
          CmdStart: f_start_q <= spi_data;
          CmdStop:  f_stop_q  <= spi_data;
          CmdStep:  f_step_q  <= spi_data;
          CmdDwell: dwell_q   <= spi_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: a monitor pops expected tuning words from a scoreboard
// on every ftw_valid pulse; the stimulus block checks static outputs between steps.
module tb_dds_sweep_ctrl;

  logic        clk_100M = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  spi_cmd = 8'h00;
  logic        spi_cmd_done = 1'b0;
  logic [31:0] spi_data = 32'h0;
  logic        spi_data_done = 1'b0;
  logic [31:0] ftw;
  logic        ftw_valid;
  logic        sweeping;
  logic        err;
  logic [31:0] cur_freq;

  always #5 clk_100M = ~clk_100M;

  dds_sweep_ctrl #(
    .FTW_MULT   (43),
    .SYNC_STAGES(2)
  ) dut (
    .clk_100M     (clk_100M),
    .rst_n        (rst_n),
    .spi_cmd      (spi_cmd),
    .spi_cmd_done (spi_cmd_done),
    .spi_data     (spi_data),
    .spi_data_done(spi_data_done),
    .ftw          (ftw),
    .ftw_valid    (ftw_valid),
    .sweeping     (sweeping),
    .err          (err),
    .cur_freq     (cur_freq)
  );

  typedef struct {
    logic [31:0] ftw;
    logic [31:0] freq;
    int          gap;  // expected cycles since previous pulse, 0 = unchecked
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk_100M) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk_100M) begin
    if (rst_n && ftw_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid_ftw", ftw, 32'hx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_ftw", ftw, e.ftw);
        chk("pulse_cur_freq", cur_freq, e.freq);
        if (e.gap != 0) chk("pulse_gap", 32'(cyc - last_cyc), 32'(e.gap));
      end
      last_cyc = cyc;
    end
  end

  task automatic push(input logic [31:0] f, input logic [31:0] fr, input int g);
    exp_t e;
    e.ftw = f;
    e.freq = fr;
    e.gap = g;
    sb.push_back(e);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk_100M);
    spi_cmd = c;
    spi_cmd_done = 1'b1;
    repeat (4) @(negedge clk_100M);
    spi_cmd_done = 1'b0;
    repeat (3) @(negedge clk_100M);
  endtask

  task automatic send_data(input logic [31:0] d);
    @(negedge clk_100M);
    spi_data = d;
    spi_data_done = 1'b1;
    repeat (4) @(negedge clk_100M);
    spi_data_done = 1'b0;
    repeat (3) @(negedge clk_100M);
  endtask

  task automatic wr(input logic [7:0] c, input logic [31:0] d);
    send_cmd(c);
    send_data(d);
  endtask

  task automatic wait_empty(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk_100M);
      #1;
      n++;
    end
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ftw"}, ftw, 32'd0);
    chk({tag, "_ftw_valid"}, {31'd0, ftw_valid}, 32'd0);
    chk({tag, "_sweeping"}, {31'd0, sweeping}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_cur_freq"}, cur_freq, 32'd0);
  endtask

  initial begin
    int n;
    // Reset state
    #23;
    chk_all_zero("reset");
    @(negedge clk_100M);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_100M);

    // Fixed frequency, with latency from done edge (SYNC_STAGES + 1 + 2 = 5)
    send_cmd(8'h01);
    push(32'd43000, 32'd1000, 0);
    @(negedge clk_100M);
    spi_data = 32'd1000;
    spi_data_done = 1'b1;
    n = 0;
    while (!ftw_valid && n < 20) begin
      @(negedge clk_100M);
      n++;
    end
    chk("fix_latency", 32'(n), 32'd5);
    repeat (2) @(negedge clk_100M);
    spi_data_done = 1'b0;
    repeat (5) @(negedge clk_100M);
    wait_empty(20);
    chk("fix_ftw", ftw, 32'd43000);
    chk("fix_cur_freq", cur_freq, 32'd1000);
    chk("fix_sweeping", {31'd0, sweeping}, 32'd0);

    // Single sweep 100..400 step 100, dwell 5 -> 8 cycles per point
    wr(8'h02, 32'd100);
    wr(8'h03, 32'd400);
    wr(8'h04, 32'd100);
    wr(8'h05, 32'd5);
    push(32'd4300, 32'd100, 0);
    push(32'd8600, 32'd200, 8);
    push(32'd12900, 32'd300, 8);
    push(32'd17200, 32'd400, 8);
    send_cmd(8'h06);
    chk("once_sweeping", {31'd0, sweeping}, 32'd1);
    wait_empty(100);
    repeat (30) @(negedge clk_100M);
    chk("once_done_sweeping", {31'd0, sweeping}, 32'd0);
    chk("once_hold_ftw", ftw, 32'd17200);

    // Continuous sweep wraps, then halt mid-dwell
    push(32'd4300, 32'd100, 0);
    push(32'd8600, 32'd200, 8);
    push(32'd12900, 32'd300, 8);
    push(32'd17200, 32'd400, 8);
    push(32'd4300, 32'd100, 8);
    send_cmd(8'h08);
    wait_empty(100);
    send_cmd(8'h07);
    repeat (40) @(negedge clk_100M);
    chk("halt_sweeping", {31'd0, sweeping}, 32'd0);
    chk("halt_ftw", ftw, 32'd4300);
    chk("halt_err", {31'd0, err}, 32'd0);

    // Error: zero step
    wr(8'h04, 32'd0);
    send_cmd(8'h06);
    repeat (10) @(negedge clk_100M);
    chk("err_step0", {31'd0, err}, 32'd1);
    chk("err_step0_sweeping", {31'd0, sweeping}, 32'd0);
    send_cmd(8'h07);
    chk("err_clear1", {31'd0, err}, 32'd0);
    // Error: start > stop
    wr(8'h04, 32'd100);
    wr(8'h02, 32'd500);
    wr(8'h03, 32'd100);
    send_cmd(8'h06);
    repeat (10) @(negedge clk_100M);
    chk("err_order", {31'd0, err}, 32'd1);
    send_cmd(8'h07);
    chk("err_clear2", {31'd0, err}, 32'd0);
    chk("err_ftw_kept", ftw, 32'd4300);

    // Carry-out terminates sweep after two points; ftw is Hz*43 mod 2^32
    wr(8'h02, 32'hFFFF_FF00);
    wr(8'h03, 32'hFFFF_FFFF);
    wr(8'h04, 32'h0000_0080);
    push(32'hFFFF_D500, 32'hFFFF_FF00, 0);
    push(32'hFFFF_EA80, 32'hFFFF_FF80, 8);
    send_cmd(8'h06);
    wait_empty(100);
    repeat (30) @(negedge clk_100M);
    chk("ovf_sweeping", {31'd0, sweeping}, 32'd0);
    chk("ovf_ftw", ftw, 32'hFFFF_EA80);

    // Abort a long-dwell sweep with a fixed-frequency write
    wr(8'h02, 32'd100);
    wr(8'h03, 32'd400);
    wr(8'h05, 32'd200);
    push(32'd4300, 32'd100, 0);
    send_cmd(8'h08);
    wait_empty(50);
    push(32'd86000, 32'd2000, 0);
    wr(8'h01, 32'd2000);
    repeat (20) @(negedge clk_100M);
    wait_empty(20);
    chk("abort_sweeping", {31'd0, sweeping}, 32'd0);
    chk("abort_ftw", ftw, 32'd86000);
    chk("abort_cur_freq", cur_freq, 32'd2000);
    repeat (250) @(negedge clk_100M);
    chk("abort_ftw_stable", ftw, 32'd86000);

    // Asynchronous reset mid-dwell
    push(32'd4300, 32'd100, 0);
    send_cmd(8'h08);
    wait_empty(50);
    repeat (5) @(negedge clk_100M);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk_100M);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_100M);
    chk("post_reset_ftw", ftw, 32'd0);
    chk("post_reset_sweeping", {31'd0, sweeping}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
